// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        CONFIG     = 3'd0,
        IDLE       = 3'd1,
        ISSUE      = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4
    } arb_state_t;

    localparam logic [7:0]  DEFAULT_DIVIDER       = 8'd16;
    localparam int unsigned DEFAULT_START_TIMEOUT = 64;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle for the UART transmit arbiter: requester side and UART side.
// slave = arbiter view, master = requesters/UART view.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 en;
    logic                 clk_divider_valid;
    logic [7:0]           clk_divider;
    logic                 tx_data_valid;
    logic [7:0]           tx_data;
    logic                 transmitter_busy;
    logic [IW-1:0]        grant_id;
    logic                 arb_busy;
    logic                 timeout_err;

    modport slave (
        input  req_valid, req_data, req_last, transmitter_busy,
        output req_ready, en, clk_divider_valid, clk_divider,
               tx_data_valid, tx_data, grant_id, arb_busy, timeout_err
    );

    modport master (
        output req_valid, req_data, req_last, transmitter_busy,
        input  req_ready, en, clk_divider_valid, clk_divider,
               tx_data_valid, tx_data, grant_id, arb_busy, timeout_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid bit at or above the
// pointer, wrapping, as a one-hot grant plus its index.
module rr_picker #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan N positions starting at the pointer; first hit wins.
    always_comb begin
        int unsigned pos;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        pos     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(i_ptr) + k;
            if (pos >= N) pos = pos - N;
            if (!o_any && i_valid[pos]) begin
                o_any        = 1'b1;
                o_grant[pos] = 1'b1;
                o_idx        = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ
// byte-stream requesters. Programs the divider once after reset.
// Optional packet lock: define UART_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter logic [7:0]  DIVIDER       = DEFAULT_DIVIDER,
    parameter int unsigned START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

    arb_state_t         r_state, w_next;
    logic [IW-1:0]      r_ptr, r_grant_id, w_ptr_next;
    logic [7:0]         r_tx_data, r_clk_div;
    logic               r_en, r_div_valid, r_timeout_err;
    logic [CW-1:0]      r_cnt;

    logic [NUM_REQ-1:0] w_cand, w_pick, w_req_ready;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_any, w_grant, w_timeout, w_done;
    logic [7:0]         w_sel_data;
    logic               w_tx_data_valid, w_arb_busy;

`ifdef UART_ARB_LOCK_EN
    logic               r_lock, r_last, w_sel_last;
    logic [NUM_REQ-1:0] w_owner;

    // While locked only the owner of the packet in progress may win.
    always_comb begin
        w_owner             = '0;
        w_owner[r_grant_id] = 1'b1;
        w_cand              = r_lock ? (bus.req_valid & w_owner) : bus.req_valid;
    end
`else
    assign w_cand = bus.req_valid;
`endif

    rr_picker #(.N(NUM_REQ)) u_picker (
        .i_valid (w_cand),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_grant    = (r_state == IDLE) && w_pick_any && !bus.transmitter_busy;
    assign w_timeout  = (r_state == WAIT_START) && !bus.transmitter_busy &&
                        (r_cnt == CW'(START_TIMEOUT - 1));
    assign w_done     = (r_state == WAIT_DONE) && !bus.transmitter_busy;
    assign w_ptr_next = (r_grant_id == IW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    // Byte (and last flag) of the winning requester.
    always_comb begin
        w_sel_data = '0;
`ifdef UART_ARB_LOCK_EN
        w_sel_last = 1'b0;
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_pick[k]) begin
                w_sel_data = bus.req_data[8*k +: 8];
`ifdef UART_ARB_LOCK_EN
                w_sel_last = bus.req_last[k];
`endif
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= CONFIG;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            CONFIG:     w_next = IDLE;
            IDLE:       if (w_grant) w_next = ISSUE;
            ISSUE:      w_next = WAIT_START;
            WAIT_START: begin
                if (bus.transmitter_busy) w_next = WAIT_DONE;
                else if (w_timeout)       w_next = IDLE;
            end
            WAIT_DONE:  if (!bus.transmitter_busy) w_next = IDLE;
            default:    w_next = CONFIG;
        endcase
    end

    // Combinational outputs. arb_busy excludes CONFIG so that every output
    // reads 0 in the cycle after reset.
    always_comb begin
        w_req_ready     = w_grant ? w_pick : '0;
        w_tx_data_valid = (r_state == ISSUE);
        w_arb_busy      = (r_state == ISSUE) || (r_state == WAIT_START) ||
                          (r_state == WAIT_DONE);
    end

    // Datapath: config pulse, capture on grant, timeout counter, pointer/lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en          <= 1'b0;
            r_div_valid   <= 1'b0;
            r_clk_div     <= '0;
            r_tx_data     <= '0;
            r_grant_id    <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            r_lock        <= 1'b0;
            r_last        <= 1'b0;
`endif
        end else begin
            if (r_state == CONFIG) begin
                r_en        <= 1'b1;
                r_div_valid <= 1'b1;
                r_clk_div   <= DIVIDER;
            end else begin
                r_div_valid <= 1'b0;
            end

            if (w_grant) begin
                r_tx_data  <= w_sel_data;
                r_grant_id <= w_pick_idx;
`ifdef UART_ARB_LOCK_EN
                r_last     <= w_sel_last;
`endif
            end

            if (r_state == ISSUE)           r_cnt <= '0;
            else if (r_state == WAIT_START) r_cnt <= r_cnt + 1'b1;

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
                r_ptr         <= w_ptr_next;
`ifdef UART_ARB_LOCK_EN
                r_lock        <= 1'b0;
`endif
            end

            if (w_done) begin
`ifdef UART_ARB_LOCK_EN
                // Lock is taken after a non-last byte and released only once
                // the last byte has finished; the pointer stays put meanwhile.
                if (r_last) begin
                    r_lock <= 1'b0;
                    r_ptr  <= w_ptr_next;
                end else begin
                    r_lock <= 1'b1;
                end
`else
                r_ptr <= w_ptr_next;
`endif
            end
        end
    end

    assign bus.req_ready         = w_req_ready;
    assign bus.tx_data_valid     = w_tx_data_valid;
    assign bus.arb_busy          = w_arb_busy;
    assign bus.en                = r_en;
    assign bus.clk_divider_valid = r_div_valid;
    assign bus.clk_divider       = r_clk_div;
    assign bus.tx_data           = r_tx_data;
    assign bus.grant_id          = r_grant_id;
    assign bus.timeout_err       = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with requester queues, a UART
// busy model and a grant/byte scoreboard. Honours UART_ARB_LOCK_EN.
module tb_uart_tx_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned FRAME = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .DIVIDER       (8'd16),
        .START_TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [8:0]  rq [N][$];
    exp_t        exp_q[$];
    int          grant_q[$];
    bit          chk_grants  = 0;
    logic [N-1:0] prev_ready = '0;
    bit          uart_dead   = 0;
    int          pend_start  = 0;
    int          frame_left  = 0;
    logic        tb_busy     = 1'b0;
    int          last_grant_cyc = 0;
    int          grant_gap   = 0;

    function automatic bit any_pending();
        bit p;
        p = 0;
        for (int k = 0; k < N; k++) if (rq[k].size() > 0) p = 1;
        return p;
    endfunction

    task automatic drive_inputs();
        logic [8:0] h;
        for (int k = 0; k < N; k++) begin
            h = '0;
            if (rq[k].size() > 0) h = rq[k][0];
            bus.req_valid[k]       = (rq[k].size() > 0);
            bus.req_data[8*k +: 8] = h[7:0];
            bus.req_last[k]        = h[8];
        end
        bus.transmitter_busy = tb_busy;
    endtask

    task automatic monitor();
        int   id;
        int   g;
        exp_t e;
        logic [8:0] h;
        if (rst) begin
            prev_ready = '0;
            return;
        end
        if (bus.req_ready != '0) begin
            vectors++;
            if (!$onehot(bus.req_ready)) begin
                miscompares++;
                $display("FAIL ready_onehot: got %b required one-hot", bus.req_ready);
            end
            id = 0;
            for (int k = 0; k < N; k++) if (bus.req_ready[k]) id = k;
            h = '0;
            if (rq[id].size() > 0) h = rq[id][0];
            exp_q.push_back('{id: id, data: h[7:0]});
            if (chk_grants) begin
                vectors++;
                if (grant_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_grant: got requester %0d required none", id);
                end else begin
                    g = grant_q.pop_front();
                    if (id !== g) begin
                        miscompares++;
                        $display("FAIL grant_order: got requester %0d required %0d", id, g);
                    end
                end
            end
            grant_gap      = cyc - last_grant_cyc;
            last_grant_cyc = cyc;
        end
        if (prev_ready != '0 || bus.tx_data_valid) begin
            vectors++;
            if (bus.tx_data_valid !== (prev_ready != '0)) begin
                miscompares++;
                $display("FAIL issue_timing: got tx_data_valid=%b required %b",
                         bus.tx_data_valid, (prev_ready != '0));
            end
        end
        if (bus.tx_data_valid === 1'b1) begin
            pend_start = 2;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL tx_unexpected: got byte %02h required none", bus.tx_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.tx_data !== e.data || int'(bus.grant_id) != e.id) begin
                    miscompares++;
                    $display("FAIL uart_rx: got byte %02h id %0d required byte %02h id %0d",
                             bus.tx_data, bus.grant_id, e.data, e.id);
                end
            end
        end
        prev_ready = bus.req_ready;
    endtask

    // One clock: retire accepts, advance UART model, drive, then sample.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++)
            if (prev_ready[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        if (pend_start > 0) begin
            pend_start--;
            if (pend_start == 0 && !uart_dead) begin
                tb_busy    = 1'b1;
                frame_left = FRAME;
            end
        end else if (frame_left > 0) begin
            frame_left--;
            if (frame_left == 0) tb_busy = 1'b0;
        end
        drive_inputs();
        #1;
        monitor();
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while ((any_pending() || grant_q.size() > 0 || exp_q.size() > 0 ||
                tb_busy || pend_start > 0) && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s_complete: got %0d grants outstanding after %0d cycles required 0",
                     name, grant_q.size(), budget);
        end
    endtask

    task automatic do_reset();
        wait_done(200, "drain");
        for (int k = 0; k < N; k++) rq[k].delete();
        exp_q.delete();
        grant_q.delete();
        chk_grants = 0;
        uart_dead  = 0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({bus.req_ready, bus.en, bus.clk_divider_valid, bus.clk_divider, bus.tx_data_valid,
             bus.tx_data, bus.grant_id, bus.arb_busy, bus.timeout_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got en=%b dv=%b div=%0d txv=%b busy=%b err=%b required all 0",
                     bus.en, bus.clk_divider_valid, bus.clk_divider, bus.tx_data_valid,
                     bus.arb_busy, bus.timeout_err);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (bus.clk_divider_valid !== 1'b1 || bus.clk_divider !== 8'd16 || bus.en !== 1'b1) begin
            miscompares++;
            $display("FAIL config_pulse: got dv=%b div=%0d en=%b required 1 16 1",
                     bus.clk_divider_valid, bus.clk_divider, bus.en);
        end
        step();
        vectors++;
        if (bus.clk_divider_valid !== 1'b0 || bus.clk_divider !== 8'd16 || bus.en !== 1'b1) begin
            miscompares++;
            $display("FAIL config_hold: got dv=%b div=%0d en=%b required 0 16 1",
                     bus.clk_divider_valid, bus.clk_divider, bus.en);
        end
        repeat (5) step();
        vectors++;
        if (bus.en !== 1'b1 || bus.arb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL en_sticky: got en=%b arb_busy=%b required 1 0", bus.en, bus.arb_busy);
        end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        chk_grants = 1;
        grant_q.push_back(2);
        rq[2].push_back({1'b0, 8'hA5});
        n = 0;
        do begin
            step();
            n++;
        end while (bus.req_ready == '0 && n < 20);
        vectors++;
        if (bus.req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_ready: got %b required 0100", bus.req_ready);
        end
        step();
        vectors++;
        if (bus.tx_data_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_issue: got txv=%b data=%02h required 1 a5",
                     bus.tx_data_valid, bus.tx_data);
        end
        step();
        vectors++;
        if (bus.req_ready !== 4'b0000 || bus.tx_data_valid !== 1'b0 || bus.tx_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_one_cycle: got ready=%b txv=%b data=%02h required 0000 0 a5",
                     bus.req_ready, bus.tx_data_valid, bus.tx_data);
        end
        wait_done(100, "single");
    endtask

    task automatic test_all4();
        do_reset();
        chk_grants = 1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) begin
                rq[k].push_back({1'b0, 8'h10 + 8'(k)});
                grant_q.push_back(k);
            end
        wait_done(400, "all4");
    endtask

    task automatic test_back_to_back();
        do_reset();
        chk_grants = 1;
        for (int k = 0; k < 3; k++) begin
            rq[3].push_back({1'b0, 8'hC0 + 8'(k)});
            grant_q.push_back(3);
        end
        wait_done(200, "b2b");
        // grant, ISSUE, one WAIT_START cycle of model latency, FRAME busy, one release cycle
        vectors++;
        if (grant_gap != 3 + int'(FRAME) + 1) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d cycles required %0d", grant_gap, 3 + FRAME + 1);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        chk_grants = 1;
        uart_dead  = 1;
        grant_q.push_back(0);
        rq[0].push_back({1'b0, 8'h5A});
        n = 0;
        do begin
            step();
            n++;
        end while (bus.tx_data_valid !== 1'b1 && n < 20);
        repeat (64) step();
        vectors++;
        if (bus.timeout_err !== 1'b0 || bus.arb_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early: got err=%b busy=%b required 0 1",
                     bus.timeout_err, bus.arb_busy);
        end
        step();
        vectors++;
        if (bus.timeout_err !== 1'b1 || bus.arb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_set: got err=%b busy=%b required 1 0",
                     bus.timeout_err, bus.arb_busy);
        end
        uart_dead = 0;
        rq[0].push_back({1'b0, 8'h60});
        rq[1].push_back({1'b0, 8'h61});
        grant_q.push_back(1);
        grant_q.push_back(0);
        wait_done(200, "after_timeout");
        vectors++;
        if (bus.timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: got %b required 1", bus.timeout_err);
        end
    endtask

    task automatic test_reset_wait_done();
        int n;
        do_reset();
        chk_grants = 1;
        grant_q.push_back(1);
        rq[1].push_back({1'b0, 8'h77});
        n = 0;
        do begin
            step();
            n++;
        end while (tb_busy !== 1'b1 && n < 30);
        step();
        step();
        vectors++;
        if (bus.arb_busy !== 1'b1 || tb_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_done_reached: got arb_busy=%b uart_busy=%b required 1 1",
                     bus.arb_busy, tb_busy);
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({bus.req_ready, bus.en, bus.clk_divider_valid, bus.clk_divider, bus.tx_data_valid,
             bus.tx_data, bus.grant_id, bus.arb_busy, bus.timeout_err} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got en=%b dv=%b div=%0d data=%02h id=%0d busy=%b required all 0",
                     bus.en, bus.clk_divider_valid, bus.clk_divider, bus.tx_data,
                     bus.grant_id, bus.arb_busy);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (bus.clk_divider_valid !== 1'b1 || bus.clk_divider !== 8'd16 || bus.en !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_reconfig: got dv=%b div=%0d en=%b required 1 16 1",
                     bus.clk_divider_valid, bus.clk_divider, bus.en);
        end
        wait_done(100, "midreset");
    endtask

    task automatic test_lock();
        int n;
        do_reset();
        chk_grants = 1;
        rq[1].push_back({1'b0, 8'hB1});
        rq[1].push_back({1'b0, 8'hB2});
        rq[1].push_back({1'b1, 8'hB3});
`ifdef UART_ARB_LOCK_EN
        grant_q = '{1, 1, 1, 0};
`else
        grant_q = '{1, 0, 1, 1};
`endif
        n = 0;
        do begin
            step();
            n++;
        end while (grant_q.size() == 4 && n < 20);
        rq[0].push_back({1'b0, 8'h0A});
        wait_done(200, "lock");
    endtask

    initial begin
        drive_inputs();
        test_reset();
        test_single();
        test_all4();
        test_back_to_back();
        test_timeout();
        test_reset_wait_done();
        test_lock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
